// File: rtl/param_updown_counter.sv
// Parameterised up/down counter with saturate, wrap, bounce and one-shot modes.
// Define PARAM_UDC_WRAPCNT_EN to build the saturating 8-bit wrap/reversal event counter.
module param_updown_counter #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              up_i,
    input  logic              load_i,
    input  logic [WIDTH-1:0]  load_val_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic [1:0]        mode_i,
    input  logic [WIDTH-1:0]  lo_lim_i,
    input  logic [WIDTH-1:0]  hi_lim_i,
    output logic [WIDTH-1:0]  count_o,
    output logic              dir_o,
    output logic              at_min_o,
    output logic              at_max_o,
    output logic              wrap_pulse_o,
    output logic              done_o,
    output logic [7:0]        wrap_cnt_o
);

    localparam logic [1:0] MODE_SAT     = 2'b00;
    localparam logic [1:0] MODE_WRAP    = 2'b01;
    localparam logic [1:0] MODE_BOUNCE  = 2'b10;
    localparam logic [1:0] MODE_ONESHOT = 2'b11;

    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;

    logic             lim_bad;
    logic             eff_up;
    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             over_hi, reach_hi, under_lo, reach_lo;
    logic [WIDTH-1:0] load_clamped;

    assign lim_bad  = lo_lim_i > hi_lim_i;
    assign eff_up   = (mode_i == MODE_BOUNCE) ? dir_q : up_i;
    assign step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step_i};
    assign sum      = {1'b0, count_q} + step_ext;
    assign diff     = {1'b0, count_q} - step_ext;

    // diff[WIDTH] is the borrow: the subtraction went below zero.
    assign over_hi  = sum > {1'b0, hi_lim_i};
    assign reach_hi = sum >= {1'b0, hi_lim_i};
    assign under_lo = diff[WIDTH] | (diff[WIDTH-1:0] < lo_lim_i);
    assign reach_lo = diff[WIDTH] | (diff[WIDTH-1:0] <= lo_lim_i);

    always_comb begin
        load_clamped = load_val_i;
        if (lim_bad || (load_val_i < lo_lim_i)) begin
            load_clamped = lo_lim_i;
        end else if (load_val_i > hi_lim_i) begin
            load_clamped = hi_lim_i;
        end
    end

    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        wrap_d  = 1'b0;
        done_d  = done_q;
        if (load_i) begin
            count_d = load_clamped;
            dir_d   = 1'b1;
            done_d  = 1'b0;
        end else if (en_i && !lim_bad && !((mode_i == MODE_ONESHOT) && done_q)) begin
            if (count_q < lo_lim_i) begin
                count_d = lo_lim_i;
            end else if (count_q > hi_lim_i) begin
                count_d = hi_lim_i;
            end else if (step_i != '0) begin
                unique case (mode_i)
                    MODE_WRAP: begin
                        if (eff_up) begin
                            count_d = over_hi ? lo_lim_i : sum[WIDTH-1:0];
                            wrap_d  = over_hi;
                        end else begin
                            count_d = under_lo ? hi_lim_i : diff[WIDTH-1:0];
                            wrap_d  = under_lo;
                        end
                    end
                    MODE_BOUNCE: begin
                        if (eff_up) begin
                            count_d = reach_hi ? hi_lim_i : sum[WIDTH-1:0];
                            wrap_d  = reach_hi;
                            dir_d   = !reach_hi;
                        end else begin
                            count_d = reach_lo ? lo_lim_i : diff[WIDTH-1:0];
                            wrap_d  = reach_lo;
                            dir_d   = reach_lo;
                        end
                    end
                    default: begin
                        if (eff_up) begin
                            count_d = over_hi ? hi_lim_i : sum[WIDTH-1:0];
                        end else begin
                            count_d = under_lo ? lo_lim_i : diff[WIDTH-1:0];
                        end
                        if (mode_i == MODE_ONESHOT) begin
                            done_d = eff_up ? reach_hi : reach_lo;
                        end
                    end
                endcase
            end
        end
        // done only has meaning in one-shot mode
        if (mode_i != MODE_ONESHOT) begin
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            dir_q   <= 1'b1;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

`ifdef PARAM_UDC_WRAPCNT_EN
    logic [7:0] wrap_cnt_q, wrap_cnt_d;

    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if (wrap_d && (wrap_cnt_q != 8'hFF)) begin
            wrap_cnt_d = wrap_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrap_cnt_q <= '0;
        end else begin
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign wrap_cnt_o = wrap_cnt_q;
`else
    assign wrap_cnt_o = '0;
`endif

    assign count_o      = count_q;
    assign dir_o        = (mode_i == MODE_BOUNCE) ? dir_q : up_i;
    assign at_min_o     = count_q == lo_lim_i;
    assign at_max_o     = count_q == hi_lim_i;
    assign wrap_pulse_o = wrap_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench for param_updown_counter: directed scenarios then randomized traffic,
// checked against an integer reference model of the counter rules.
module tb_param_updown_counter;

    localparam int WIDTH  = 8;
    localparam int STEP_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              up = 1'b1;
    logic              load = 1'b0;
    logic [WIDTH-1:0]  load_val = '0;
    logic [STEP_W-1:0] step = '0;
    logic [1:0]        mode = 2'b00;
    logic [WIDTH-1:0]  lo_lim = '0;
    logic [WIDTH-1:0]  hi_lim = '1;
    logic [WIDTH-1:0]  count;
    logic              dir, at_min, at_max, wrap_pulse, done;
    logic [7:0]        wrap_cnt;

    param_updown_counter #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .load_i(load),
        .load_val_i(load_val), .step_i(step), .mode_i(mode),
        .lo_lim_i(lo_lim), .hi_lim_i(hi_lim), .count_o(count), .dir_o(dir),
        .at_min_o(at_min), .at_max_o(at_max), .wrap_pulse_o(wrap_pulse),
        .done_o(done), .wrap_cnt_o(wrap_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c;
        bit d;
        bit amin;
        bit amax;
        bit wp;
        bit dn;
        int wc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // reference state
    int m_c = 0;
    bit m_d = 1'b1;
    bit m_done = 1'b0;
    bit m_wp = 1'b0;
    int m_wc = 0;

    function automatic void check(string name, int act, int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endfunction

    // Evaluate one clock edge of the counter rules using plain integers.
    function automatic void model_step();
        int lo, hi, stp, t;
        bit eu;
        lo = int'(lo_lim);
        hi = int'(hi_lim);
        stp = int'(step);
        m_wp = 1'b0;
        if (rst) begin
            m_c = 0; m_d = 1'b1; m_done = 1'b0; m_wc = 0;
            return;
        end
        if (load) begin
            if (lo > hi) m_c = lo;
            else if (int'(load_val) < lo) m_c = lo;
            else if (int'(load_val) > hi) m_c = hi;
            else m_c = int'(load_val);
            m_done = 1'b0;
            m_d = 1'b1;
        end else if (en && lo <= hi && !(mode == 2'b11 && m_done)) begin
            if (m_c < lo) m_c = lo;
            else if (m_c > hi) m_c = hi;
            else if (stp != 0) begin
                eu = (mode == 2'b10) ? m_d : up;
                t = eu ? m_c + stp : m_c - stp;
                case (mode)
                    2'b01: begin
                        if (t > hi) begin m_c = lo; m_wp = 1'b1; end
                        else if (t < lo) begin m_c = hi; m_wp = 1'b1; end
                        else m_c = t;
                    end
                    2'b10: begin
                        if (eu && t >= hi) begin m_c = hi; m_d = 1'b0; m_wp = 1'b1; end
                        else if (!eu && t <= lo) begin m_c = lo; m_d = 1'b1; m_wp = 1'b1; end
                        else m_c = t;
                    end
                    default: begin
                        m_c = (t > hi) ? hi : (t < lo) ? lo : t;
                        if (mode == 2'b11 && ((eu && m_c == hi) || (!eu && m_c == lo)))
                            m_done = 1'b1;
                    end
                endcase
            end
        end
        if (mode != 2'b11) m_done = 1'b0;
`ifdef PARAM_UDC_WRAPCNT_EN
        if (m_wp && m_wc < 255) m_wc++;
`else
        m_wc = 0;
`endif
    endfunction

    task automatic tick();
        exp_t e;
        model_step();
        e.c = m_c;
        e.d = (mode == 2'b10) ? m_d : up;
        e.amin = (m_c == int'(lo_lim));
        e.amax = (m_c == int'(hi_lim));
        e.wp = m_wp;
        e.dn = m_done;
        e.wc = m_wc;
        sb.push_back(e);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("count", int'(count), e.c);
                check("dir", int'(dir), int'(e.d));
                check("at_min", int'(at_min), int'(e.amin));
                check("at_max", int'(at_max), int'(e.amax));
                check("wrap_pulse", int'(wrap_pulse), int'(e.wp));
                check("done", int'(done), int'(e.dn));
                check("wrap_cnt", int'(wrap_cnt), e.wc);
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : driver
        @(negedge clk);
        // reset overrides load and en
        rst = 1'b1; load = 1'b1; en = 1'b1; load_val = 8'd77;
        tick(); tick();
        rst = 1'b0; load = 1'b0; en = 1'b0;
        tick();

        // saturate up to 10
        mode = 2'b00; lo_lim = 8'd0; hi_lim = 8'd10; up = 1'b1; step = 4'd3; en = 1'b1;
        repeat (5) tick();
        // step 0 holds
        step = 4'd0;
        repeat (2) tick();

        // wrap down
        mode = 2'b01; lo_lim = 8'd2; hi_lim = 8'd9; en = 1'b0; load = 1'b1; load_val = 8'd5;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b0; step = 4'd2;
        repeat (3) tick();
        en = 1'b0;
        tick();

        // bounce 0..4
        rst = 1'b1; tick(); rst = 1'b0;
        mode = 2'b10; lo_lim = 8'd0; hi_lim = 8'd4; step = 4'd1; en = 1'b1; up = 1'b0;
        repeat (9) tick();

        // one-shot then reload
        rst = 1'b1; tick(); rst = 1'b0;
        mode = 2'b11; lo_lim = 8'd0; hi_lim = 8'd5; up = 1'b1; step = 4'd2; en = 1'b1;
        repeat (5) tick();
        load = 1'b1; load_val = 8'd1; tick(); load = 1'b0;
        tick();
        // leaving one-shot clears done
        repeat (3) tick();
        mode = 2'b00; en = 1'b0; tick();

        // load clamp and inverted limits
        lo_lim = 8'd0; hi_lim = 8'd50; load = 1'b1; load_val = 8'd200; tick();
        load = 1'b0; lo_lim = 8'd20; hi_lim = 8'd10; en = 1'b1; up = 1'b1; step = 4'd5;
        repeat (2) tick();
        load = 1'b1; load_val = 8'd3; tick(); load = 1'b0;
        // out-of-range count jumps to the nearest limit
        lo_lim = 8'd30; hi_lim = 8'd40; tick();
        lo_lim = 8'd0; hi_lim = 8'd20; tick();
        // near the top of the range, sums exceed WIDTH bits
        lo_lim = 8'd0; hi_lim = 8'd255; load = 1'b1; load_val = 8'd250; tick(); load = 1'b0;
        step = 4'd15; repeat (2) tick();
        mode = 2'b01; load = 1'b1; tick(); load = 1'b0; tick();

        // 300 wrap events
        rst = 1'b1; tick(); rst = 1'b0;
        mode = 2'b01; lo_lim = 8'd0; hi_lim = 8'd0; up = 1'b1; step = 4'd1; en = 1'b1;
        repeat (300) tick();
        en = 1'b0; repeat (2) tick();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            load = ($urandom_range(0, 9) == 0);
            en = ($urandom_range(0, 3) != 0);
            up = $urandom_range(0, 1) == 1;
            step = STEP_W'($urandom_range(0, 15));
            load_val = WIDTH'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) begin
                lo_lim = WIDTH'($urandom_range(0, 120));
                hi_lim = WIDTH'($urandom_range(0, 255));
            end
            tick();
        end
        rst = 1'b0; load = 1'b0; en = 1'b0;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
